bit_serializer: RTL and testbench

Parallel-to-serial front end feeding the sequence detector's single-bit `in` stream. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. A one-word holding buffer lets back-to-back words stream with no idle cycle between them. It also flags the first and last bit of each word, so downstream logic can align detections to word boundaries.

---
 rtl/bit_serializer.sv | 143 ++++++++++++++
 tb/tb_bit_serializer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per
// clock. A one-word holding register lets consecutive words stream with no
// gap. frame_start / frame_end mark the first and last bit of each word.
module bit_serializer #(
    parameter int WIDTH      = 8,    // 2..32
    parameter bit MSB_FIRST  = 1'b1, // 1: bit WIDTH-1 leaves first
    parameter bit IDLE_LEVEL = 1'b0  // serial_out level when no word is shifting
) (
    input  logic             clk,
    input  logic             reset,        // synchronous, active-low
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;     // word being shifted out
    logic [CNT_W-1:0] cnt_q, cnt_d;   // index of the bit currently presented
    logic [WIDTH-1:0] hr_q, hr_d;     // next word, waiting for the current one to end
    logic             hf_q, hf_d;     // hr_q holds a word
    logic             so_q, so_d;
    logic             sv_q, sv_d;
    logic             fs_q, fs_d;
    logic             fe_q, fe_d;

    logic accept;

    // Move the shift register one place toward its output end.
    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST) shift_once = {sr[WIDTH-2:0], 1'b0};
        else           shift_once = {1'b0, sr[WIDTH-1:1]};
    endfunction

    // The bit sitting at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST) out_bit = sr[WIDTH-1];
        else           out_bit = sr[0];
    endfunction

    // Ready depends only on the holding flag, so there is no valid->ready path.
    assign data_ready = ~hf_q;
    assign accept     = data_valid & data_ready;

    // Next-state logic: word loading, shifting, holding-register hand-off.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        hr_d    = hr_q;
        hf_d    = hf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_d    = data_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    // Word end: the held word has priority; ready is low while it waits.
                    if (hf_q) begin
                        sr_d  = hr_q;
                        cnt_d = '0;
                        hf_d  = 1'b0;
                    end else if (accept) begin
                        sr_d  = data_in;
                        cnt_d = '0;
                    end else begin
                        sr_d    = '0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    sr_d  = shift_once(sr_q);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (accept) begin
                        hr_d = data_in;
                        hf_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output flops take the values that the post-edge state will present.
    always_comb begin
        sv_d = (state_d == ST_SHIFT);
        so_d = sv_d ? out_bit(sr_d) : IDLE_LEVEL;
        fs_d = sv_d && (cnt_d == '0);
        fe_d = sv_d && (cnt_d == CNT_LAST);
    end

    // State register with synchronous active-low reset; a partial word is discarded.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            hr_q    <= '0;
            hf_q    <= 1'b0;
            so_q    <= IDLE_LEVEL;
            sv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            hr_q    <= hr_d;
            hf_q    <= hf_d;
            so_q    <= so_d;
            sv_q    <= sv_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

    assign serial_out   = so_q;
    assign serial_valid = sv_q;
    assign frame_start  = fs_q;
    assign frame_end    = fe_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: scoreboard of expected serial bits, filled
// when a handshake is driven and drained by per-instance output monitors.
// One MSB-first instance carries most scenarios; an LSB-first instance
// covers bit ordering in the other direction.
module tb_bit_serializer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in, data_in_l;
    logic             data_valid, data_valid_l;
    logic             data_ready, serial_out, serial_valid, frame_start, frame_end;
    logic             data_ready_l, serial_out_l, serial_valid_l, frame_start_l, frame_end_l;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct packed {
        logic b;
        logic s;
        logic e;
    } exp_t;

    exp_t sb_m[$];
    exp_t sb_l[$];

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .data_ready(data_ready), .serial_out(serial_out), .serial_valid(serial_valid),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    bit_serializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .data_in(data_in_l), .data_valid(data_valid_l),
        .data_ready(data_ready_l), .serial_out(serial_out_l), .serial_valid(serial_valid_l),
        .frame_start(frame_start_l), .frame_end(frame_end_l)
    );

    // Expected bit stream of one word, in transmit order.
    task automatic push_word(input logic [WIDTH-1:0] w, input bit lsb);
        for (int i = 0; i < WIDTH; i++) begin
            exp_t x;
            x.b = lsb ? w[i] : w[WIDTH-1-i];
            x.s = (i == 0);
            x.e = (i == WIDTH - 1);
            if (lsb) sb_l.push_back(x);
            else     sb_m.push_back(x);
        end
    endtask

    // Monitor for the MSB-first instance.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (serial_valid === 1'b1) begin
                if (sb_m.size() == 0) begin
                    errors++;
                    $display("FAIL sb_main_extra: serial_valid=1 with no bit pending, serial_out=%b", serial_out);
                end else begin
                    exp_t x;
                    x = sb_m.pop_front();
                    if ({serial_out, frame_start, frame_end} !== x) begin
                        errors++;
                        $display("FAIL sb_main_bit: got out/start/end=%b%b%b expected %b%b%b",
                                 serial_out, frame_start, frame_end, x.b, x.s, x.e);
                    end
                end
            end else if ({serial_valid, serial_out, frame_start, frame_end} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_main: got valid/out/start/end=%b%b%b%b expected 0000",
                         serial_valid, serial_out, frame_start, frame_end);
            end
        end
    end

    // Monitor for the LSB-first instance.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (serial_valid_l === 1'b1) begin
                if (sb_l.size() == 0) begin
                    errors++;
                    $display("FAIL sb_lsb_extra: serial_valid=1 with no bit pending, serial_out=%b", serial_out_l);
                end else begin
                    exp_t x;
                    x = sb_l.pop_front();
                    if ({serial_out_l, frame_start_l, frame_end_l} !== x) begin
                        errors++;
                        $display("FAIL sb_lsb_bit: got out/start/end=%b%b%b expected %b%b%b",
                                 serial_out_l, frame_start_l, frame_end_l, x.b, x.s, x.e);
                    end
                end
            end else if ({serial_valid_l, serial_out_l, frame_start_l, frame_end_l} !== 4'b0000) begin
                errors++;
                $display("FAIL idle_lsb: got valid/out/start/end=%b%b%b%b expected 0000",
                         serial_valid_l, serial_out_l, frame_start_l, frame_end_l);
            end
        end
    end

    // Offer a word on the main instance; returns just after the accepting edge.
    task automatic send_word(input logic [WIDTH-1:0] w);
        int n;
        n = 0;
        @(negedge clk);
        data_in    = w;
        data_valid = 1'b1;
        while (data_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 64) begin
            errors++;
            $display("FAIL send_timeout: data_ready=%b after %0d cycles, required 1", data_ready, n);
        end else begin
            push_word(w, 1'b0);
            @(posedge clk);
        end
    endtask

    // Wait for an instance to go idle with its scoreboard empty; reports valid cycles seen.
    task automatic drain(input bit lsb, output int valid_cycles);
        int n;
        bit done;
        valid_cycles = 0;
        done = 1'b0;
        for (n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            #1;
            if (lsb) begin
                if (serial_valid_l === 1'b0 && sb_l.size() == 0) done = 1'b1;
                else if (serial_valid_l === 1'b1) valid_cycles++;
            end else begin
                if (serial_valid === 1'b0 && sb_m.size() == 0) done = 1'b1;
                else if (serial_valid === 1'b1) valid_cycles++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: instance lsb=%0d still busy after %0d cycles, required idle", lsb, n);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b0;
        data_in      = '0;
        data_valid   = 1'b0;
        data_in_l    = '0;
        data_valid_l = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks += 6;
        if (data_ready !== 1'b1)   begin errors++; $display("FAIL reset_ready: got %b required 1", data_ready); end
        if (serial_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", serial_valid); end
        if (serial_out !== 1'b0)   begin errors++; $display("FAIL reset_out: got %b required 0", serial_out); end
        if (frame_start !== 1'b0)  begin errors++; $display("FAIL reset_fstart: got %b required 0", frame_start); end
        if (frame_end !== 1'b0)    begin errors++; $display("FAIL reset_fend: got %b required 0", frame_end); end
        if (data_ready_l !== 1'b1) begin errors++; $display("FAIL reset_ready_lsb: got %b required 1", data_ready_l); end
        mon_en = 1'b1;
    endtask

    task automatic test_single_word();
        int vc;
        send_word(8'hB5);
        @(negedge clk);
        data_valid = 1'b0;
        checks += 3;
        if (serial_valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid: got %b required 1", serial_valid); end
        if (frame_start !== 1'b1)  begin errors++; $display("FAIL single_first_start: got %b required 1", frame_start); end
        if (serial_out !== 1'b1)   begin errors++; $display("FAIL single_first_bit: got %b required 1", serial_out); end
        drain(1'b0, vc);
        checks++;
        if (vc != 7) begin errors++; $display("FAIL single_length: got %0d further valid cycles required 7", vc); end
    endtask

    task automatic test_back_to_back();
        int vc;
        fork
            begin
                send_word(8'hA0);
                send_word(8'h0D);
                send_word(8'hFF);
                @(negedge clk);
                data_valid = 1'b0;
            end
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (serial_valid !== 1'b1 && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                checks++;
                if (w >= 20) begin
                    errors++;
                    $display("FAIL b2b_start_timeout: serial_valid=%b after %0d cycles, required 1", serial_valid, w);
                end else begin
                    for (int k = 1; k <= 3 * WIDTH; k++) begin
                        logic exp_fs, exp_fe, exp_rdy;
                        exp_fs  = (k % WIDTH) == 1;
                        exp_fe  = (k % WIDTH) == 0;
                        exp_rdy = (k == 1) || (k == WIDTH + 1) || (k > 2 * WIDTH);
                        checks += 4;
                        if (serial_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap: cycle %0d serial_valid=%b required 1", k, serial_valid); end
                        if (frame_start !== exp_fs) begin errors++; $display("FAIL b2b_fstart: cycle %0d got %b required %b", k, frame_start, exp_fs); end
                        if (frame_end !== exp_fe)   begin errors++; $display("FAIL b2b_fend: cycle %0d got %b required %b", k, frame_end, exp_fe); end
                        if (data_ready !== exp_rdy) begin errors++; $display("FAIL b2b_ready: cycle %0d got %b required %b", k, data_ready, exp_rdy); end
                        @(negedge clk);
                    end
                    checks++;
                    if (serial_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_idle: got serial_valid=%b required 0", serial_valid); end
                end
            end
        join
        drain(1'b0, vc);
    endtask

    task automatic test_lsb_first();
        int vc;
        @(negedge clk);
        checks++;
        if (data_ready_l !== 1'b1) begin errors++; $display("FAIL lsb_ready: got %b required 1", data_ready_l); end
        data_in_l    = 8'h01;
        data_valid_l = 1'b1;
        push_word(8'h01, 1'b1);
        @(posedge clk);
        @(negedge clk);
        data_valid_l = 1'b0;
        checks += 3;
        if (serial_valid_l !== 1'b1) begin errors++; $display("FAIL lsb_valid: got %b required 1", serial_valid_l); end
        if (frame_start_l !== 1'b1)  begin errors++; $display("FAIL lsb_fstart: got %b required 1", frame_start_l); end
        if (serial_out_l !== 1'b1)   begin errors++; $display("FAIL lsb_first_bit: got %b required 1", serial_out_l); end
        drain(1'b1, vc);
        checks++;
        if (vc != 7) begin errors++; $display("FAIL lsb_length: got %0d further valid cycles required 7", vc); end
    endtask

    task automatic test_mid_reset();
        int vc;
        send_word(8'hFF);
        send_word(8'h55);
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Bit 4 of 0xFF is on the line and 0x55 waits in the holding register.
        checks += 3;
        if (serial_valid !== 1'b1) begin errors++; $display("FAIL midrst_busy: got serial_valid=%b required 1", serial_valid); end
        if (data_ready !== 1'b0)   begin errors++; $display("FAIL midrst_held: got data_ready=%b required 0", data_ready); end
        if (frame_start !== 1'b0)  begin errors++; $display("FAIL midrst_bit4: got frame_start=%b required 0", frame_start); end
        reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (serial_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b required 0", serial_valid); end
        if (data_ready !== 1'b1)   begin errors++; $display("FAIL midrst_ready: got %b required 1", data_ready); end
        if (serial_out !== 1'b0)   begin errors++; $display("FAIL midrst_out: got %b required 0", serial_out); end
        if ({frame_start, frame_end} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b required 00", {frame_start, frame_end}); end
        sb_m.delete();
        reset = 1'b1;
        vc = 0;
        for (int i = 0; i < 3 * WIDTH; i++) begin
            @(negedge clk);
            if (serial_valid !== 1'b0) vc++;
        end
        checks++;
        if (vc != 0) begin errors++; $display("FAIL midrst_flushed: got %0d valid cycles after reset required 0", vc); end
    endtask

    task automatic test_last_bit_accept();
        int vc;
        send_word(8'h3C);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (6) @(negedge clk);
        @(negedge clk);
        checks += 2;
        if (frame_end !== 1'b1)  begin errors++; $display("FAIL lastbit_fend: got %b required 1", frame_end); end
        if (data_ready !== 1'b1) begin errors++; $display("FAIL lastbit_ready: got %b required 1", data_ready); end
        data_in    = 8'hC3;
        data_valid = 1'b1;
        push_word(8'hC3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        checks += 3;
        if (serial_valid !== 1'b1) begin errors++; $display("FAIL lastbit_nogap: got serial_valid=%b required 1", serial_valid); end
        if (frame_start !== 1'b1)  begin errors++; $display("FAIL lastbit_fstart: got %b required 1", frame_start); end
        if (serial_out !== 1'b1)   begin errors++; $display("FAIL lastbit_first: got %b required 1", serial_out); end
        drain(1'b0, vc);
        checks++;
        if (vc != 7) begin errors++; $display("FAIL lastbit_length: got %0d further valid cycles required 7", vc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_lsb_first();
        test_mid_reset();
        test_last_bit_accept();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_m.size() != 0 || sb_l.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d/%0d bits never emitted, required 0/0", sb_m.size(), sb_l.size());
        end
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
